x_23k640_responder: RTL and testbench
=====================================

Name: x_23K640_responder

Overview:
- Synthesizable SPI responder that emulates one 23K640 SPI SRAM (8 KiB, SPI mode 0, MSB first).
- It is the slave end of the per-device cs/so/si/sck link that our multi-SRAM controller drives.
- Used for in-system loopback, FPGA bring-up without populated SRAMs, and as the device model in controller benches.
- All pins are oversampled in the i_clk domain. i_sck is a data input, not a clock.

Parameters:
- ADDR_W, 13, internal byte-address width; memory depth is 2^ADDR_W.
- PAGE_W, 5, page-offset width; page size is 2^PAGE_W bytes for page mode.
- SYNC_STAGES, 2, synchronizer depth on i_sck, i_cs and i_si.

Ports:
- i_clk  in  1  system clock; the single clock of the block.
- i_rst_n  in  1  asynchronous active-low reset.
- i_sck  in  1  SPI clock from controller (o_sck).
- i_cs  in  1  chip select, active low (controller o_cs_N).
- i_si  in  1  serial data from controller (o_so_N).
- o_so  out  1  serial data to controller (i_si_N).
- o_busy  out  1  high while i_cs (synchronized) is low.
- o_mode  out  2  current status-register mode bits [7:6].

Behaviour:
- Reset (async assert, sync deassert inside block):
  - o_so=0, o_busy=0, o_mode=2'b00.
  - Status register=8'h00, state=IDLE, bit counter=0.
  - Memory contents are not reset.
- Timing constraint: i_sck high and low phases each at least 4 i_clk cycles.
- Pin path: sync -> edge detect. Rise and fall pulses appear SYNC_STAGES+1 cycles after the pin edge.
- Rising sck with cs low: shift the synchronized si into rx_shreg[0]; increment bit counter (3 bits).
- Falling sck with cs low: o_so <= tx_shreg[7]; tx_shreg shifts left with 0 fill. o_so updates 1 cycle after the fall pulse.
- A byte completes on the 8th rising edge (counter wraps 7->0). All state actions below occur on byte completion.
- States and transitions:
  - IDLE: cs falls -> CMD.
  - CMD: decode opcode.
    - 0x03 READ -> ADDR_HI.
    - 0x02 WRITE -> ADDR_HI.
    - 0x05 RDSR -> STAT_RD: tx_shreg loaded with status immediately, so the first bit appears on the next falling sck.
    - 0x01 WRSR -> STAT_WR.
    - Any other opcode -> IGNORE.
  - ADDR_HI: latch the address high byte -> ADDR_LO. Bits above ADDR_W-1 of the 16-bit address are don't-care.
  - ADDR_LO: latch the address low byte.
    - READ: load tx_shreg with mem[addr] -> RDATA.
    - WRITE: -> WDATA.
  - RDATA: on each completed byte, advance addr and load tx_shreg with mem[addr].
  - WDATA: on each completed byte, write mem[addr] <= rx byte in the same cycle, then advance addr.
  - STAT_WR: status <= {rx[7:6], 5'b0, rx[0]} -> IGNORE.
  - STAT_RD: reload status on every byte, so repeated reads return the same value.
  - IGNORE: shift nothing meaningful; o_so held 0.
- Address advance by mode (status[7:6]):
  - 00 byte: after the first data byte -> IGNORE. Further clocks have no effect and o_so=0.
  - 10 page: addr[PAGE_W-1:0] increments and wraps; upper bits are fixed.
  - 01 sequential: full addr increments and wraps from 2^ADDR_W-1 to 0.
  - 11 reserved: treated as byte mode, but status still stores 11.
- cs rising, from any state:
  - Next cycle: state=IDLE, counter=0, tx_shreg=0, o_so=0, o_busy=0.
  - A partial write byte is discarded; a completed byte is already written.
- Simultaneous sck edge and cs rise in the same cycle: cs rise wins, and the edge is ignored.
- sck edges while cs is high are ignored.
- Memory read is asynchronous from the array at load time. A write and a read of the same addr never occur in one cycle.

Decomposition:
- Shared package x_23K640_pkg holds:
  - Opcode constants: READ=8'h03, WRITE=8'h02, RDSR=8'h05, WRSR=8'h01.
  - Mode encodings: BYTE=2'b00, PAGE=2'b10, SEQ=2'b01.
  - State enum typedef.
- Sub-module x_23K640_pinsync contains the synchronizer plus rise/fall detect for sck, and the synchronizer for cs and si. Parameter: SYNC_STAGES.

Test Plan:
- Byte-mode write then read:
  - Stimulus: WRITE 0x0010 data 0xA5; cs high; READ 0x0010.
  - Required: o_so returns 0xA5 MSB first; extra 8 clocks return 0x00.
- Status registers:
  - Stimulus: WRSR 0x41, then RDSR twice in one cs.
  - Required: both bytes read 0x41; o_mode=2'b01.
- Page mode wrap:
  - Stimulus: status 0x80; WRITE 0x003E data 0x11,0x22,0x33; then READ 0x0020.
  - Required: mem[0x3E]=0x11, mem[0x3F]=0x22, mem[0x20]=0x33; reading 0x0020 returns 0x33.
- Sequential wrap:
  - Stimulus: status 0x40; WRITE 0x1FFF data 0xDE,0xAD; then READ 0x1FFF for 2 bytes.
  - Required: returns 0xDE,0xAD; mem[0x0000]=0xAD. Address 0xFFFF aliases to 0x1FFF.
- Abort and unknown opcode:
  - Stimulus: WRITE 0x0005 with data cut after 5 bits; then opcode 0x9F followed by 16 clocks.
  - Required: mem[0x0005] unchanged; o_so stays 0 and state returns to IDLE on cs high.
- Reset mid-read:
  - Stimulus: assert i_rst_n low during bit 3 of RDATA.
  - Required: o_so=0, o_busy=0, o_mode=00 immediately; memory contents survive.
  - Required: after release, a new READ works. A READ issued while cs stays low after reset is not recognized until cs toggles.

Source files
------------

// File: rtl/x_23k640_responder_pkg.sv
// Shared constants and state encoding for the 23K640 SPI SRAM responder.
`timescale 1ns/1ps
package x_23K640_pkg;

  // Instruction opcodes understood by the device.
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WRSR  = 8'h01;

  // Status register mode field [7:6]; 2'b11 is reserved and behaves as byte mode.
  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_PAGE = 2'b10;
  localparam logic [1:0] MODE_SEQ  = 2'b01;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_CMD     = 4'd1,
    ST_ADDR_HI = 4'd2,
    ST_ADDR_LO = 4'd3,
    ST_RDATA   = 4'd4,
    ST_WDATA   = 4'd5,
    ST_STAT_RD = 4'd6,
    ST_STAT_WR = 4'd7,
    ST_IGNORE  = 4'd8
  } state_e;

endpackage

// File: rtl/x_23k640_responder_pinsync.sv
// Pin synchronizers for sck/cs/si plus edge detection. All outputs are
// registered so that edge pulses, the cs level and si line up in one cycle.
`timescale 1ns/1ps
module x_23K640_pinsync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sck_i,
  input  logic cs_i,
  input  logic si_i,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic cs_rise_o,
  output logic cs_fall_o,
  output logic cs_low_o,
  output logic si_o
);

  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] si_sync_q;
  // Counts cycles since reset release; a cs fall seen while the chain is
  // still flushing its reset value is not a real select and is suppressed.
  logic [SYNC_STAGES:0]   primed_q;
  logic sck_prev_q, cs_prev_q;
  logic sck_rise_q, sck_fall_q, cs_rise_q, cs_fall_q, si_q;
  logic sck_s, cs_s, si_s;

  assign sck_s = sck_sync_q[SYNC_STAGES-1];
  assign cs_s  = cs_sync_q[SYNC_STAGES-1];
  assign si_s  = si_sync_q[SYNC_STAGES-1];

  // Synchronizer chains, previous-value registers and registered edge pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_sync_q <= '0;
      cs_sync_q  <= '1;
      si_sync_q  <= '0;
      primed_q   <= '0;
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b1;
      sck_rise_q <= 1'b0;
      sck_fall_q <= 1'b0;
      cs_rise_q  <= 1'b0;
      cs_fall_q  <= 1'b0;
      si_q       <= 1'b0;
    end else begin
      sck_sync_q[0] <= sck_i;
      cs_sync_q[0]  <= cs_i;
      si_sync_q[0]  <= si_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sck_sync_q[i] <= sck_sync_q[i-1];
        cs_sync_q[i]  <= cs_sync_q[i-1];
        si_sync_q[i]  <= si_sync_q[i-1];
      end
      primed_q   <= {primed_q[SYNC_STAGES-1:0], 1'b1};
      sck_prev_q <= sck_s;
      cs_prev_q  <= cs_s;
      sck_rise_q <= sck_s & ~sck_prev_q;
      sck_fall_q <= ~sck_s & sck_prev_q;
      cs_rise_q  <= cs_s & ~cs_prev_q;
      cs_fall_q  <= ~cs_s & cs_prev_q & primed_q[SYNC_STAGES];
      si_q       <= si_s;
    end
  end

  assign sck_rise_o = sck_rise_q;
  assign sck_fall_o = sck_fall_q;
  assign cs_rise_o  = cs_rise_q;
  assign cs_fall_o  = cs_fall_q;
  assign cs_low_o   = ~cs_prev_q;
  assign si_o       = si_q;

endmodule

// File: rtl/x_23k640_responder.sv
// 23K640 SPI SRAM responder (mode 0, MSB first), oversampled in i_clk.
`timescale 1ns/1ps
module x_23k640_responder
  import x_23K640_pkg::*;
#(
  parameter int ADDR_W      = 13,
  parameter int PAGE_W      = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sck,
  input  logic       i_cs,
  input  logic       i_si,
  output logic       o_so,
  output logic       o_busy,
  output logic [1:0] o_mode
);

  logic [1:0] rst_sync_q;
  logic       rst_n_s;
  logic       sck_rise_s, sck_fall_s, cs_rise_s, cs_fall_s, cs_low_s, si_s;

  state_e              state_q, state_d;
  logic [2:0]          bitcnt_q, bitcnt_d;
  logic [6:0]          rx_q, rx_d;
  logic [7:0]          tx_q, tx_d;
  logic [7:0]          status_q, status_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic                so_q, so_d;
  logic                busy_q;
  logic                mem_we_s;
  logic                byte_done_s;
  logic                one_shot_s;
  logic [7:0]          rx_byte_s;
  logic [ADDR_W-1:0]   addr_lo_s, addr_next_s;
  logic [7:0]          mem_q [0:(2**ADDR_W)-1];

  // Next data address for the current mode; byte/reserved modes never advance.
  function automatic logic [ADDR_W-1:0] advance(input logic [ADDR_W-1:0] a, input logic [1:0] mode);
    case (mode)
      MODE_PAGE: return {a[ADDR_W-1:PAGE_W], a[PAGE_W-1:0] + PAGE_W'(1)};
      MODE_SEQ:  return a + ADDR_W'(1);
      default:   return a;
    endcase
  endfunction

  // Reset synchronizer: assert asynchronously, release on a clock edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_n_s = rst_sync_q[1];

  x_23K640_pinsync #(.SYNC_STAGES(SYNC_STAGES)) u_pinsync (
    .clk_i      (i_clk),
    .rst_ni     (rst_n_s),
    .sck_i      (i_sck),
    .cs_i       (i_cs),
    .si_i       (i_si),
    .sck_rise_o (sck_rise_s),
    .sck_fall_o (sck_fall_s),
    .cs_rise_o  (cs_rise_s),
    .cs_fall_o  (cs_fall_s),
    .cs_low_o   (cs_low_s),
    .si_o       (si_s)
  );

  assign rx_byte_s   = {rx_q, si_s};
  assign byte_done_s = sck_rise_s & (bitcnt_q == 3'd7);
  assign one_shot_s  = (status_q[7:6] != MODE_PAGE) && (status_q[7:6] != MODE_SEQ);
  assign addr_lo_s   = {addr_q[ADDR_W-1:8], rx_byte_s};
  assign addr_next_s = advance(addr_q, status_q[7:6]);

  // FSM state register.
  always_ff @(posedge i_clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: cs release always wins, otherwise advance per completed byte.
  always_comb begin
    state_d = state_q;
    if (cs_rise_s) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE) begin
      if (cs_fall_s) state_d = ST_CMD;
      else           state_d = ST_IDLE;
    end else if (byte_done_s) begin
      case (state_q)
        ST_CMD: begin
          case (rx_byte_s)
            OP_READ, OP_WRITE: state_d = ST_ADDR_HI;
            OP_RDSR:           state_d = ST_STAT_RD;
            OP_WRSR:           state_d = ST_STAT_WR;
            default:           state_d = ST_IGNORE;
          endcase
        end
        ST_ADDR_HI:         state_d = ST_ADDR_LO;
        ST_ADDR_LO:         state_d = wr_q ? ST_WDATA : ST_RDATA;
        ST_RDATA, ST_WDATA: state_d = one_shot_s ? ST_IGNORE : state_q;
        ST_STAT_WR:         state_d = ST_IGNORE;
        ST_STAT_RD:         state_d = ST_STAT_RD;
        ST_IGNORE:          state_d = ST_IGNORE;
        default:            state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FSM outputs and datapath: shift on sck edges, act on byte completion.
  always_comb begin
    bitcnt_d = bitcnt_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    status_d = status_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    so_d     = so_q;
    mem_we_s = 1'b0;
    if (cs_rise_s || (state_q == ST_IDLE)) begin
      bitcnt_d = 3'd0;
      tx_d     = 8'h00;
      so_d     = 1'b0;
    end else if (sck_rise_s) begin
      rx_d     = rx_byte_s[6:0];
      bitcnt_d = bitcnt_q + 3'd1;
      if (byte_done_s) begin
        case (state_q)
          ST_CMD: begin
            wr_d = (rx_byte_s == OP_WRITE);
            if (rx_byte_s == OP_RDSR) tx_d = status_q;
            else                      tx_d = 8'h00;
          end
          ST_ADDR_HI: addr_d = {rx_byte_s[ADDR_W-9:0], 8'h00};
          ST_ADDR_LO: begin
            addr_d = addr_lo_s;
            if (wr_q) tx_d = 8'h00;
            else      tx_d = mem_q[addr_lo_s];
          end
          ST_RDATA: begin
            if (one_shot_s) begin
              tx_d = 8'h00;
            end else begin
              addr_d = addr_next_s;
              tx_d   = mem_q[addr_next_s];
            end
          end
          ST_WDATA: begin
            mem_we_s = 1'b1;
            addr_d   = addr_next_s;
          end
          ST_STAT_WR: status_d = {rx_byte_s[7:6], 5'b00000, rx_byte_s[0]};
          ST_STAT_RD: tx_d = status_q;
          default:    tx_d = 8'h00;
        endcase
      end else begin
        tx_d = tx_q;
      end
    end else if (sck_fall_s) begin
      tx_d = {tx_q[6:0], 1'b0};
      if (state_q == ST_IGNORE) so_d = 1'b0;
      else                      so_d = tx_q[7];
    end else begin
      so_d = so_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      bitcnt_q <= 3'd0;
      rx_q     <= 7'd0;
      tx_q     <= 8'h00;
      status_q <= 8'h00;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      so_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      bitcnt_q <= bitcnt_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      status_q <= status_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      so_q     <= so_d;
      busy_q   <= cs_low_s;
    end
  end

  // Memory array write port; contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (mem_we_s) mem_q[addr_q] <= rx_byte_s;
  end

  assign o_so   = so_q;
  assign o_busy = busy_q;
  assign o_mode = status_q[7:6];

endmodule

// File: tb/tb_x_23k640_responder.sv
// Scoreboard bench for the 23K640 responder: a byte-level memory model
// predicts every byte returned on o_so; a monitor compares in order.
`timescale 1ns/1ps
module tb_x_23k640_responder;

  localparam int DEPTH = 8192;
  localparam int PAGE  = 32;
  localparam int HALF  = 5;

  logic clk, rst_n, sck, cs, si;
  logic so, busy;
  logic [1:0] mode;

  typedef struct packed {
    logic [7:0] val;
    logic       care;
  } exp_t;

  int         checks = 0;
  int         failures = 0;
  exp_t       exp_q[$];
  event       rx_ev;
  logic [7:0] rx_got;
  logic [7:0] m_mem [DEPTH];
  bit         m_known [DEPTH];
  logic [7:0] m_status;
  logic [7:0] txb[$];

  x_23k640_responder dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_sck   (sck),
    .i_cs    (cs),
    .i_si    (si),
    .o_so    (so),
    .o_busy  (busy),
    .o_mode  (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500us;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: every completed byte seen on o_so is matched against the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(rx_ev);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_byte unexpected actual=%02h required=none", rx_got);
      end else begin
        e = exp_q.pop_front();
        if (e.care) begin
          checks++;
          if (rx_got !== e.val) begin
            failures++;
            $display("FAIL rx_byte actual=%02h required=%02h", rx_got, e.val);
          end
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Controller side of mode 0: data set while sck low, o_so sampled before each rise.
  task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < n; i++) begin
      si = b[7-i];
      wait_clk(HALF);
      got = {got[6:0], so};
      sck = 1'b1;
      wait_clk(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [7:0] g;
    send_bits(b, 8, g);
    rx_got = g;
    -> rx_ev;
  endtask

  function automatic bit one_shot();
    return !((m_status[7:6] == 2'b10) || (m_status[7:6] == 2'b01));
  endfunction

  function automatic int adv(input int a);
    if (m_status[7:6] == 2'b10) return (a / PAGE) * PAGE + ((a + 1) % PAGE);
    else if (m_status[7:6] == 2'b01) return (a + 1) % DEPTH;
    else return a;
  endfunction

  // Reference model: what the SRAM returns for each byte of txb, updating memory/status.
  task automatic model_expect();
    exp_t e;
    logic [7:0] op;
    int a;
    op = txb[0];
    a = 0;
    if (txb.size() >= 3) a = int'({txb[1], txb[2]}) % DEPTH;
    for (int k = 0; k < txb.size(); k++) begin
      e.val  = 8'h00;
      e.care = 1'b1;
      if (op == 8'h05 && k >= 1) begin
        e.val = m_status;
      end else if ((op == 8'h03 || op == 8'h02) && k >= 3) begin
        if (k == 3 || !one_shot()) begin
          if (op == 8'h03) begin
            e.val  = m_mem[a];
            e.care = m_known[a];
          end else begin
            m_mem[a]   = txb[k];
            m_known[a] = 1'b1;
          end
          a = adv(a);
        end
      end else if (op == 8'h01 && k == 1) begin
        m_status = {txb[1][7:6], 5'b00000, txb[1][0]};
      end
      exp_q.push_back(e);
    end
  endtask

  // One chip-select framed transaction, optionally followed by a cut partial byte.
  task automatic txn(input int cut_bits, input logic [7:0] cut_val);
    logic [7:0] g;
    model_expect();
    cs = 1'b0;
    wait_clk(6);
    check("busy_active", busy, 1);
    foreach (txb[k]) send_byte(txb[k]);
    if (cut_bits > 0) send_bits(cut_val, cut_bits, g);
    wait_clk(HALF);
    cs = 1'b1;
    wait_clk(8);
    check("busy_idle", busy, 0);
    check("so_idle", so, 0);
    check("mode", mode, m_status[7:6]);
  endtask

  initial begin
    logic [7:0] g, op;
    int a13, len;
    exp_t z;
    rst_n = 1'b0; cs = 1'b1; sck = 1'b0; si = 1'b0;
    m_status = 8'h00;
    wait_clk(3);
    check("rst_so", so, 0);
    check("rst_busy", busy, 0);
    check("rst_mode", mode, 0);
    rst_n = 1'b1;
    wait_clk(10);

    // Byte mode write then read, extra byte returns zero.
    txb = {8'h02, 8'h00, 8'h10, 8'hA5};             txn(0, 8'h00);
    txb = {8'h03, 8'h00, 8'h10, 8'h00, 8'h00};      txn(0, 8'h00);
    // Status write, two status reads in one select.
    txb = {8'h01, 8'h41};                           txn(0, 8'h00);
    txb = {8'h05, 8'h00, 8'h00};                    txn(0, 8'h00);
    // Page mode wrap.
    txb = {8'h01, 8'h80};                           txn(0, 8'h00);
    txb = {8'h02, 8'h00, 8'h3E, 8'h11, 8'h22, 8'h33}; txn(0, 8'h00);
    txb = {8'h03, 8'h00, 8'h3E, 8'h00, 8'h00};      txn(0, 8'h00);
    txb = {8'h03, 8'h00, 8'h20, 8'h00};             txn(0, 8'h00);
    // Sequential wrap and high address aliasing.
    txb = {8'h01, 8'h40};                           txn(0, 8'h00);
    txb = {8'h02, 8'h1F, 8'hFF, 8'hDE, 8'hAD};      txn(0, 8'h00);
    txb = {8'h03, 8'hFF, 8'hFF, 8'h00, 8'h00};      txn(0, 8'h00);
    txb = {8'h03, 8'h00, 8'h00, 8'h00};             txn(0, 8'h00);
    // Aborted write byte and unknown opcode.
    txb = {8'h02, 8'h00, 8'h05, 8'h5A};             txn(0, 8'h00);
    txb = {8'h02, 8'h00, 8'h05};                    txn(5, 8'hFF);
    txb = {8'h9F, 8'h00, 8'h00};                    txn(0, 8'h00);
    txb = {8'h03, 8'h00, 8'h05, 8'h00};             txn(0, 8'h00);

    // Fill the two regions used by random traffic.
    txb = {8'h01, 8'h40};                           txn(0, 8'h00);
    txb = {8'h02, 8'h00, 8'h00};
    for (int i = 0; i < 64; i++) txb.push_back(8'($urandom));
    txn(0, 8'h00);
    txb = {8'h02, 8'h1F, 8'hC0};
    for (int i = 0; i < 64; i++) txb.push_back(8'($urandom));
    txn(0, 8'h00);

    // Randomized transactions.
    for (int t = 0; t < 30; t++) begin
      a13 = ($urandom_range(0, 1) == 1 ? 32'h1FC0 : 32'h0000) + $urandom_range(0, 63);
      a13 = a13 | ($urandom_range(0, 7) << 13);
      len = $urandom_range(1, 5);
      case ($urandom_range(0, 8))
        0, 1, 2: begin
          txb = {8'h03, 8'(a13 >> 8), 8'(a13)};
          for (int i = 0; i < len; i++) txb.push_back(8'h00);
        end
        3, 4, 5: begin
          txb = {8'h02, 8'(a13 >> 8), 8'(a13)};
          for (int i = 0; i < len; i++) txb.push_back(8'($urandom));
        end
        6: begin
          txb = {8'h05};
          for (int i = 0; i < len; i++) txb.push_back(8'h00);
        end
        7: txb = {8'h01, 8'($urandom)};
        default: begin
          op = 8'($urandom);
          if (op inside {8'h01, 8'h02, 8'h03, 8'h05}) op = 8'h9F;
          txb = {op, 8'h00, 8'h00};
        end
      endcase
      txn(0, 8'h00);
    end

    // Reset in the middle of a data read.
    txb = {8'h01, 8'h40};                           txn(0, 8'h00);
    z.val = 8'h00; z.care = 1'b1;
    repeat (3) exp_q.push_back(z);
    cs = 1'b0;
    wait_clk(6);
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h10);
    send_bits(8'h00, 3, g);
    wait_clk(2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_so", so, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_mode", mode, 0);
    m_status = 8'h00;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(10);
    // cs never went high after reset, so this READ must be ignored.
    repeat (4) exp_q.push_back(z);
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    wait_clk(HALF);
    cs = 1'b1;
    wait_clk(8);
    check("post_rst_busy", busy, 0);
    txb = {8'h03, 8'h00, 8'h10, 8'h00};             txn(0, 8'h00);

    wait_clk(5);
    check("exp_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
